// File: rtl/uart_pro_rx_if.sv
// Byte-strobe input and decoded-frame output bundle of the protocol deframer.
// The master side feeds bytes in and observes frames; the slave side is the deframer.
interface uart_pro_rx_if;
   logic        RX_DONE;
   logic [7:0]  RX_DATA;
   logic        FRAME_VALID;
   logic        FRAME_ERR;
   logic [7:0]  CMD_OUT;
   logic [3:0]  LEN_OUT;
   logic [79:0] DATA_OUT;
   logic        BUSY;

   modport master (
      output RX_DONE, RX_DATA,
      input  FRAME_VALID, FRAME_ERR, CMD_OUT, LEN_OUT, DATA_OUT, BUSY
   );

   modport slave (
      input  RX_DONE, RX_DATA,
      output FRAME_VALID, FRAME_ERR, CMD_OUT, LEN_OUT, DATA_OUT, BUSY
   );
endinterface

// File: rtl/uart_pro_rx.sv
// Inbound protocol deframer: hunts HEADER, then collects CMD, LEN, payload and CHK.
// Good frames update CMD_OUT/LEN_OUT/DATA_OUT with a one-cycle FRAME_VALID.
module uart_pro_rx #(
   parameter logic [7:0]  HEADER  = 8'h55,
   parameter int unsigned MAX_LEN = 10,
   parameter int unsigned TIMEOUT = 8660
) (
   input logic          CLK,
   input logic          RST,
   uart_pro_rx_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_CMD  = 3'd1,
      GET_LEN  = 3'd2,
      GET_DATA = 3'd3,
      GET_CHK  = 3'd4
   } state_t;

   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [13:0] TO_LAST   = 14'(TIMEOUT - 1);

   state_t      state, next_state;
   logic [13:0] to_cnt;
   logic [3:0]  byte_cnt, len_sh;
   logic [7:0]  cmd_sh, xor_acc;
   logic [79:0] shadow;
   logic [6:0]  slot_lsb;
   logic        active, expire, len_bad, last_data, chk_ok, is_header;
   logic        valid_set, err_set;

   assign active    = (state == GET_CMD) || (state == GET_LEN) ||
                      (state == GET_DATA) || (state == GET_CHK);
   assign is_header = (bus.RX_DATA == HEADER);
   assign len_bad   = (bus.RX_DATA > MAX_LEN_B);
   assign last_data = ((byte_cnt + 4'd1) == len_sh);
   assign chk_ok    = (bus.RX_DATA == xor_acc);
   // A strobe on the expiring cycle wins, so expiry needs a quiet cycle.
   assign expire    = active && !bus.RX_DONE && (to_cnt == TO_LAST);
   // First payload byte lands in [79:72], each later byte one slot lower.
   assign slot_lsb  = 7'd72 - {byte_cnt, 3'b000};

   // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         IDLE:     if (bus.RX_DONE && is_header) next_state = GET_CMD;
         GET_CMD:  if (bus.RX_DONE) next_state = GET_LEN;
         GET_LEN:
            if (bus.RX_DONE) begin
               if (len_bad)                   next_state = IDLE;
               else if (bus.RX_DATA == 8'h00) next_state = GET_CHK;
               else                           next_state = GET_DATA;
            end
         GET_DATA: if (bus.RX_DONE && last_data) next_state = GET_CHK;
         GET_CHK:  if (bus.RX_DONE) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
      if (expire) next_state = IDLE;
   end

   always_comb begin
      valid_set = (state == GET_CHK) && bus.RX_DONE && chk_ok;
      err_set   = expire ||
                  ((state == GET_LEN) && bus.RX_DONE && len_bad) ||
                  ((state == GET_CHK) && bus.RX_DONE && !chk_ok);
      bus.BUSY  = (state != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.FRAME_VALID <= 1'b0;
         bus.FRAME_ERR   <= 1'b0;
         bus.CMD_OUT     <= '0;
         bus.LEN_OUT     <= '0;
         bus.DATA_OUT    <= '0;
         to_cnt          <= '0;
         byte_cnt        <= '0;
         len_sh          <= '0;
         cmd_sh          <= '0;
         xor_acc         <= '0;
         shadow          <= '0;
      end else begin
         bus.FRAME_VALID <= valid_set;
         bus.FRAME_ERR   <= err_set;
         to_cnt          <= (active && !bus.RX_DONE) ? to_cnt + 14'd1 : 14'd0;
         if (bus.RX_DONE) begin
            case (state)
               IDLE:
                  if (is_header) begin
                     shadow   <= '0;
                     xor_acc  <= '0;
                     byte_cnt <= '0;
                  end
               GET_CMD: begin
                  cmd_sh  <= bus.RX_DATA;
                  xor_acc <= bus.RX_DATA;
               end
               GET_LEN:
                  if (!len_bad) begin
                     len_sh  <= bus.RX_DATA[3:0];
                     xor_acc <= xor_acc ^ bus.RX_DATA;
                  end
               GET_DATA: begin
                  shadow[slot_lsb +: 8] <= bus.RX_DATA;
                  xor_acc               <= xor_acc ^ bus.RX_DATA;
                  byte_cnt              <= byte_cnt + 4'd1;
               end
               GET_CHK:
                  if (chk_ok) begin
                     bus.DATA_OUT <= shadow;
                     bus.CMD_OUT  <= cmd_sh;
                     bus.LEN_OUT  <= len_sh;
                  end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_pro_rx.sv
// Self-checking bench for uart_pro_rx: directed spec frames plus randomized frames
// scored against a frame-level model of the protocol.
module tb_uart_pro_rx;
   localparam int         TIMEOUT = 8660;
   localparam logic [7:0] HDR     = 8'h55;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   uart_pro_rx_if bus();

   uart_pro_rx #(.HEADER(HDR), .MAX_LEN(10), .TIMEOUT(TIMEOUT)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0, err_seen = 0, both_seen = 0;

   // Frame-level model: what the last good frame should have left on the outputs.
   logic [7:0]  exp_cmd  = 8'h00;
   logic [3:0]  exp_len  = 4'h0;
   logic [79:0] exp_data = '0;
   logic [7:0]  pl [10];

   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.FRAME_VALID === 1'b1) valid_seen++;
         if (bus.FRAME_ERR === 1'b1)   err_seen++;
         if (bus.FRAME_VALID === 1'b1 && bus.FRAME_ERR === 1'b1) both_seen++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Called just after a rising edge; strobes one byte for exactly one cycle.
   task automatic put(input logic [7:0] b);
      bus.RX_DONE = 1'b1;
      bus.RX_DATA = b;
      @(posedge CLK); #1;
      bus.RX_DONE = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   // Sends HEADER,CMD,LEN,pl[0..len-1],CHK^flip with random gaps; checks the pulse.
   task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] flip,
                             input int max_gap, input bit tail);
      int v0, e0;
      logic [7:0]  chk;
      logic [79:0] d;
      bit bad;
      bad = (flip != 8'h00);
      put(HDR);
      v0 = valid_seen; e0 = err_seen;
      idle($urandom_range(max_gap, 0));
      put(cmd);
      idle($urandom_range(max_gap, 0));
      put(8'(len));
      chk = cmd ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         idle($urandom_range(max_gap, 0));
         put(pl[i]);
         chk = chk ^ pl[i];
      end
      idle($urandom_range(max_gap, 0));
      checks++;
      if (valid_seen != v0 || err_seen != e0 || bus.BUSY !== 1'b1) begin
         errors++;
         $display("FAIL mid_frame: pulses v=%0d e=%0d busy=%b, want none and busy=1",
                  valid_seen - v0, err_seen - e0, bus.BUSY);
      end
      put(chk ^ flip);
      checks++;
      if ({bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY} !== {!bad, bad, 1'b0}) begin
         errors++;
         $display("FAIL chk_pulse: valid/err/busy=%b%b%b want %b%b0",
                  bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY, !bad, bad);
      end
      if (!bad) begin
         d = '0;
         for (int i = 0; i < 10; i++) d = {d[71:0], (i < len) ? pl[i] : 8'h00};
         exp_cmd  = cmd;
         exp_len  = 4'(len);
         exp_data = d;
      end
      checks++;
      if ({bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== {exp_cmd, exp_len, exp_data}) begin
         errors++;
         $display("FAIL frame_out: got cmd=%h len=%0d data=%h want cmd=%h len=%0d data=%h",
                  bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT, exp_cmd, exp_len, exp_data);
      end
      if (tail) begin
         idle(1);
         checks++;
         if (valid_seen - v0 != int'(!bad) || err_seen - e0 != int'(bad) ||
             bus.FRAME_VALID !== 1'b0 || bus.FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL one_pulse: valid count=%0d err count=%0d want %0d/%0d",
                     valid_seen - v0, err_seen - e0, int'(!bad), int'(bad));
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      idle(1);
      checks++;
      if ({bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY, bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b e=%b busy=%b cmd=%h len=%h data=%h, want all 0",
                  bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY, bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT);
      end
   endtask

   task automatic test_good_frames();
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(8'h01, 3, 8'h00, 2, 1'b1);
      checks++;
      if (bus.DATA_OUT !== 80'h112233_00000000000000) begin
         errors++;
         $display("FAIL spec_3byte: got %h want 11223300000000000000", bus.DATA_OUT);
      end
      for (int i = 0; i < 10; i++) pl[i] = 8'(i + 1);
      send_frame(8'h07, 10, 8'h00, 1, 1'b1);
      checks++;
      if (bus.DATA_OUT !== 80'h0102030405060708090A || bus.LEN_OUT !== 4'd10) begin
         errors++;
         $display("FAIL full_frame: got len=%0d data=%h want 10 0102030405060708090a",
                  bus.LEN_OUT, bus.DATA_OUT);
      end
      send_frame(8'h02, 0, 8'h00, 1, 1'b1);
      checks++;
      if (bus.DATA_OUT !== '0 || bus.CMD_OUT !== 8'h02) begin
         errors++;
         $display("FAIL zero_len: got cmd=%h data=%h want 02 and zero", bus.CMD_OUT, bus.DATA_OUT);
      end
      pl[0] = HDR; pl[1] = HDR;
      send_frame(HDR, 2, 8'h00, 0, 1'b1);
   endtask

   task automatic test_errors();
      int e0;
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(8'h01, 3, 8'h01, 1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         put(HDR);
         e0 = err_seen;
         put(8'h07);
         put((k == 0) ? 8'h0B : 8'($urandom_range(255, 11)));
         checks++;
         if ({bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY} !== 3'b010 ||
             {bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== {exp_cmd, exp_len, exp_data}) begin
            errors++;
            $display("FAIL bad_len: v/e/busy=%b%b%b cmd=%h want 010 and cmd=%h held",
                     bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY, bus.CMD_OUT, exp_cmd);
         end
         idle(1);
         checks++;
         if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL bad_len_count: got %0d error pulses want 1", err_seen - e0);
         end
      end
   endtask

   task automatic test_noise();
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      put(8'h00); idle(2); put(8'hFF); put(8'h12); idle(3);
      checks++;
      if (bus.BUSY !== 1'b0 || valid_seen != v0 || err_seen != e0) begin
         errors++;
         $display("FAIL noise: busy=%b pulses v=%0d e=%0d want idle and none",
                  bus.BUSY, valid_seen - v0, err_seen - e0);
      end
      pl[0] = 8'hDE; pl[1] = 8'hAD;
      send_frame(8'h33, 2, 8'h00, 2, 1'b1);
   endtask

   task automatic test_timeout();
      int e0;
      put(HDR); put(8'h09); put(8'h03); put(8'hAA); put(8'hBB);
      e0 = err_seen;
      idle(TIMEOUT - 1);
      checks++;
      if (bus.FRAME_ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: err=%b busy=%b at N+TIMEOUT want 0/1", bus.FRAME_ERR, bus.BUSY);
      end
      idle(1);
      checks++;
      if ({bus.FRAME_ERR, bus.FRAME_VALID, bus.BUSY} !== 3'b100 ||
          {bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== {exp_cmd, exp_len, exp_data}) begin
         errors++;
         $display("FAIL timeout_fire: err/valid/busy=%b%b%b cmd=%h want 100 cmd=%h",
                  bus.FRAME_ERR, bus.FRAME_VALID, bus.BUSY, bus.CMD_OUT, exp_cmd);
      end
      idle(1);
      checks++;
      if (err_seen - e0 != 1 || bus.FRAME_ERR !== 1'b0) begin
         errors++;
         $display("FAIL timeout_count: got %0d error pulses want 1", err_seen - e0);
      end
      // Strobe landing exactly on the expiring cycle must keep the frame alive.
      put(HDR); put(8'h0C); put(8'h03); put(8'hAA); put(8'hBB);
      idle(TIMEOUT - 1);
      put(8'hCC);
      checks++;
      if (bus.FRAME_ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
         errors++;
         $display("FAIL timeout_race: err=%b busy=%b want 0/1", bus.FRAME_ERR, bus.BUSY);
      end
      put(8'h0C ^ 8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC);
      exp_cmd = 8'h0C; exp_len = 4'd3; exp_data = {24'hAABBCC, 56'h0};
      checks++;
      if (bus.FRAME_VALID !== 1'b1 ||
          {bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== {exp_cmd, exp_len, exp_data}) begin
         errors++;
         $display("FAIL timeout_race_frame: valid=%b cmd=%h data=%h want 1 0c aabbcc..",
                  bus.FRAME_VALID, bus.CMD_OUT, bus.DATA_OUT);
      end
      idle(1);
   endtask

   task automatic test_rst_mid();
      int v0, e0;
      put(HDR); put(8'h21); put(8'h05); put(8'h11); put(8'h22);
      v0 = valid_seen; e0 = err_seen;
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({bus.FRAME_VALID, bus.FRAME_ERR, bus.BUSY, bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT} !== '0) begin
         errors++;
         $display("FAIL async_reset: busy=%b cmd=%h len=%h data=%h want all 0",
                  bus.BUSY, bus.CMD_OUT, bus.LEN_OUT, bus.DATA_OUT);
      end
      exp_cmd = 8'h00; exp_len = 4'h0; exp_data = '0;
      idle(2);
      RST = 1'b0;
      idle(3);
      checks++;
      if (valid_seen != v0 || err_seen != e0 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: pulses v=%0d e=%0d busy=%b want none, idle",
                  valid_seen - v0, err_seen - e0, bus.BUSY);
      end
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(8'h01, 3, 8'h00, 1, 1'b1);
   endtask

   task automatic test_back_to_back();
      pl[0] = 8'hA1; pl[1] = 8'hB2;
      send_frame(8'h41, 2, 8'h00, 0, 1'b0);
      idle(1);
      pl[0] = 8'hC3;
      send_frame(8'h42, 1, 8'h00, 0, 1'b0);
      send_frame(8'h43, 0, 8'h5A, 0, 1'b0);
      idle(1);
      pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
      send_frame(8'h44, 4, 8'h00, 0, 1'b1);
   endtask

   task automatic test_random();
      int len, noise;
      logic [7:0] b, flip;
      for (int f = 0; f < 25; f++) begin
         noise = $urandom_range(2, 0);
         for (int n = 0; n < noise; n++) begin
            b = 8'($urandom);
            if (b == HDR) b = 8'h00;
            put(b);
            idle($urandom_range(2, 0));
         end
         len = $urandom_range(10, 0);
         for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
         flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         send_frame(8'($urandom), len, flip, 3, 1'b1);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_seen != 0) begin
         errors++;
         $display("FAIL exclusive: valid and err together %0d times, want 0", both_seen);
      end
   endtask

   initial begin
      bus.RX_DONE = 1'b0;
      bus.RX_DATA = 8'h00;
      test_reset();
      test_good_frames();
      test_errors();
      test_noise();
      test_timeout();
      test_rst_mid();
      test_back_to_back();
      test_random();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_pro_rx.md
# uart_pro_rx

Receive-side protocol deframer for the UART link. Consumes bytes from the byte-level UART receiver (one-cycle strobe per byte), hunts for a frame header, and collects command, length, payload and checksum. Presents the payload left-aligned on an 80-bit bus with a one-cycle valid pulse. This is the inbound counterpart of the protocol transmitter, which serialises an 80-bit buffer MSB-byte first to the UART TX.

## Interface

Parameters:
- HEADER, 8'h55: start-of-frame byte.
- MAX_LEN, 10: maximum payload bytes (80-bit bus / 8).
- TIMEOUT, 8660: inter-byte timeout in CLK cycles (two byte times at 4330 cycles/byte); counter is 14 bits.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- RX_DONE  in  1  one-cycle strobe; RX_DATA is valid this cycle.
- RX_DATA  in  8  received byte.
- FRAME_VALID  out  1  one-cycle pulse; CMD_OUT/LEN_OUT/DATA_OUT hold a new good frame.
- FRAME_ERR  out  1  one-cycle pulse on a rejected frame.
- CMD_OUT  out  8  command byte of last good frame.
- LEN_OUT  out  4  payload length of last good frame (0..10).
- DATA_OUT  out  80  payload of last good frame; first byte in [79:72], unused low bytes zero.
- BUSY  out  1  high while state is not IDLE.

## Operation

- Frame on the wire: HEADER, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ every payload byte.
- States (3-bit): IDLE, GET_CMD, GET_LEN, GET_DATA, GET_CHK. Any unused encoding returns to IDLE next cycle with no pulse.
- IDLE: on RX_DONE with RX_DATA == HEADER -> GET_CMD; clear shadow buffer, running XOR, byte counter. Non-header bytes ignored silently (no FRAME_ERR).
- GET_CMD: on RX_DONE, store CMD, XOR <= RX_DATA -> GET_LEN.
- GET_LEN: on RX_DONE: if RX_DATA > MAX_LEN -> FRAME_ERR, IDLE. Else store LEN, XOR ^= RX_DATA; LEN == 0 -> GET_CHK, else GET_DATA.
- GET_DATA: on RX_DONE, write byte into shadow byte slot (9 - count), i.e. first byte to [79:72]; XOR ^= byte; count++. When count reaches LEN -> GET_CHK.
- GET_CHK: on RX_DONE: if RX_DATA == XOR, copy shadow to DATA_OUT, CMD_OUT, LEN_OUT and pulse FRAME_VALID; else pulse FRAME_ERR. Both -> IDLE.
- Outputs CMD_OUT/LEN_OUT/DATA_OUT change only on a good frame; errors leave them unchanged.
- Timeout: in any non-IDLE state the counter increments every cycle without RX_DONE and clears on RX_DONE. Reaching TIMEOUT -> FRAME_ERR pulse, IDLE.
- A HEADER value received mid-frame is treated as ordinary data (no resync).

## Timing

- Reset values: FRAME_VALID 0, FRAME_ERR 0, CMD_OUT 0, LEN_OUT 0, DATA_OUT 0, BUSY 0, state IDLE, counters 0. RST asserted mid-frame aborts with no pulse.
- All outputs registered. FRAME_VALID/FRAME_ERR assert the cycle after the RX_DONE of the CHK byte (latency 1); data outputs update in that same cycle.
- BUSY goes high the cycle after the header strobe and low the cycle FRAME_VALID/FRAME_ERR asserts.
- Timeout: with last strobe in cycle N, FRAME_ERR asserts in cycle N + TIMEOUT + 1. RX_DONE coincident with the expiring cycle wins; the byte is consumed and the counter clears.
- Back-to-back: a HEADER strobe in the cycle right after the pulse cycle starts a new frame; no dead cycles required.
- FRAME_VALID and FRAME_ERR never assert together; at most one pulse per frame.

## Test plan

- Good frame 55 01 03 11 22 33 CHK=01^03^11^22^33=0x02 -> FRAME_VALID one cycle after CHK; CMD_OUT 01, LEN_OUT 3, DATA_OUT 112233_00000000000000.
- Full frame LEN=10, bytes 01..0A, correct CHK -> DATA_OUT 0102030405060708090A; zero-length frame 55 02 00 02 -> valid, DATA_OUT all zero.
- Bad checksum (previous frame with CHK 0x03) -> FRAME_ERR pulse, outputs keep prior frame values; LEN=0x0B -> FRAME_ERR immediately after LEN byte.
- Noise 00 FF 12 before header -> ignored, no pulse; following good frame received correctly.
- Stop after 2 payload bytes -> FRAME_ERR exactly TIMEOUT+1 cycles after last strobe, BUSY drops; RX_DONE arriving on the expiring cycle -> no error, frame continues.
- RST pulse mid-payload -> all outputs 0 asynchronously, no pulse; next good frame decoded normally.
